alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked ALU: next generation of the 9-bit combinational datapath ALU.
//  Registers operands, results and status flags, and runs multi-bit shifts as a multicycle operation.
//  Adds a sticky HALT state and an illegal-opcode flag.
//  Sits between decode (operand/opcode producer) and writeback (result consumer) in the core.
// PARAMETERS
//  WIDTH     9  datapath width in bits (>=4)
//  CLA_GROUP 3  adder lookahead group size; groups ripple carry; last group may be partial
//  SHAMT_W   4  width of shift amount, taken from b[SHAMT_W-1:0]
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  reset     in   1      synchronous, active-high
//  in_valid  in   1      request present
//  in_ready  out  1      block can accept request this cycle
//  opcode    in   4      operation (encoding below)
//  a, b      in   WIDTH  operands
//  out_valid out  1      result/flags valid
//  out_ready in   1      consumer accepts result
//  out       out  WIDTH  result
//  flag_z/n/c/v out 1    zero, negative (out[MSB]), carry, signed overflow
//  illegal   out  1      result came from undefined opcode 1100-1110
//  halted    out  1      HALT accepted; sticky until reset
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR (true OR), 2 NOT a, 3 ADD, 4 MOV a, 5 SLL, 6 SRL, 7 SUB a-b,
//   8 ADDI, 9 SUBI (same as 3/7; b carries imm), A MOVI (out=b), B NOP (out=0), F HALT.
//  Reset: state=IDLE; out=0, all flags=0, out_valid=0, illegal=0, halted=0; any op in flight discarded.
//  Accept = in_valid & in_ready. in_ready = (IDLE) | (DONE & out_ready). 0 in SHIFT/HALTED/reset.
//  FSM: IDLE -accept non-shift-> DONE; -accept shift, shamt>0-> SHIFT; -shamt==0-> DONE;
//   -accept HALT-> HALTED. SHIFT: one bit/cycle, shamt counter decrements; reaching 0 -> DONE.
//   DONE: out_valid=1; out_ready & no accept -> IDLE; out_ready & accept -> same routing as IDLE.
//   HALTED: in_ready=0, out_valid=0, halted=1; leave only by reset.
//  Latency: accept at edge T -> out_valid from T+1 (non-shift, shift by 0); shift by k -> T+1+k.
//  out and flags held stable while out_valid & ~out_ready.
//  Add/sub: out = a + (b or ~b) + cin, cin=1 for SUB/SUBI; modulo 2^WIDTH; CLA groups of CLA_GROUP.
//   flag_c = carry out of MSB (SUB: 1 = no borrow); flag_v = signed two's-complement overflow.
//  Shifts: logical, zero fill; shamt>=WIDTH gives out=0; flag_c = last bit shifted out (0 if shamt=0).
//  Logic/MOV/MOVI/NOP/illegal: flag_c=0, flag_v=0. flag_z=(out==0), flag_n=out[WIDTH-1], always.
//  Illegal opcode: out=0, flag_z=1, illegal=1, 1-cycle latency; does not halt.
//  HALT produces no result; an op in DONE is still presented and must be consumed first.
//  Inputs are sampled only on accept; a/b/opcode changes while busy are ignored.
// TESTING (WIDTH=9, CLA_GROUP=3)
//  ADD a=1FF b=001 -> out=000 z=1 c=1 v=0 n=0, out_valid at T+1
//  ADD a=0FF b=001 -> out=100 n=1 v=1 c=0; SUB a=005 b=007 -> out=1FE n=1 c=0 v=0
//  SLL a=003 b=004 -> in_ready low 4 cycles, out=030 c=0 at T+5; SRL a=101 b=00F -> out=000 z=1
//  Backpressure: out_ready=0 for 3 cycles after ADD -> out/flags stable, in_ready=0; then
//   out_ready=1 with new in_valid -> back-to-back accept, next result at following cycle
//  Opcode E -> illegal=1 out=0; then HALT -> halted=1, in_ready=0 for 10 cycles despite in_valid
//  reset asserted mid SLL by 8 -> next cycle out_valid=0 out=0 flags=0, IDLE, in_ready=1

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU: single-cycle arithmetic/logic, bit-serial multicycle shifts,
// sticky HALT and illegal-opcode reporting.
//  state   | meaning
//  IDLE    | no result pending, ready for a request
//  SHIFT   | shifting one bit per cycle, cnt_q steps remaining
//  DONE    | result and flags presented, waiting for out_ready
//  HALTED  | HALT accepted, frozen until reset
module alu_pipe #(
   parameter int WIDTH     = 9,
   parameter int CLA_GROUP = 3,
   parameter int SHAMT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             illegal,
   output logic             halted
);

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_NOT  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SUB  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_SUBI = 4'h9;
   localparam logic [3:0] OP_MOVI = 4'hA;
   localparam logic [3:0] OP_NOP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_HALTED} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, ill_q, ill_d;
   logic               upd_zn;

   logic               accept;
   logic               sub_op;
   logic [WIDTH-1:0]   b_eff, p, g, sum;
   logic               sum_c, sum_v;
   logic [SHAMT_W-1:0] shamt;

   assign in_ready  = ~reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign shamt     = b[SHAMT_W-1:0];

   assign sub_op = (opcode == OP_SUB) || (opcode == OP_SUBI);
   assign b_eff  = sub_op ? ~b : b;
   assign p      = a ^ b_eff;
   assign g      = a & b_eff;

   // Lookahead inside each CLA_GROUP-bit group; group carries ripple into the next group.
   always_comb begin
      logic [WIDTH:0] cy;
      logic           cg, term, gen;
      cy    = '0;
      cy[0] = sub_op;
      cg    = 1'b0;
      term  = 1'b0;
      gen   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i % CLA_GROUP == 0) cg = cy[i];
         term = cg;
         for (int j = 0; j < WIDTH; j++)
            if ((j / CLA_GROUP == i / CLA_GROUP) && (j <= i)) term = term & p[j];
         for (int j = 0; j < WIDTH; j++) begin
            if ((j / CLA_GROUP == i / CLA_GROUP) && (j <= i)) begin
               gen = g[j];
               for (int k = 0; k < WIDTH; k++)
                  if ((k > j) && (k <= i)) gen = gen & p[k];
               term = term | gen;
            end
         end
         cy[i+1] = term;
      end
      sum   = p ^ cy[WIDTH-1:0];
      sum_c = cy[WIDTH];
   end

   assign sum_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      z_d     = z_q;
      n_d     = n_q;
      c_d     = c_q;
      v_d     = v_q;
      ill_d   = ill_q;
      upd_zn  = 1'b0;

      case (state_q)
         S_SHIFT: begin
            if (left_q) begin
               c_d   = res_q[WIDTH-1];
               res_d = {res_q[WIDTH-2:0], 1'b0};
            end else begin
               c_d   = res_q[0];
               res_d = {1'b0, res_q[WIDTH-1:1]};
            end
            cnt_d  = cnt_q - SHAMT_W'(1);
            upd_zn = 1'b1;
            if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
         end
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: ;
      endcase

      if (accept && (opcode == OP_HALT)) begin
         state_d = S_HALTED;
      end else if (accept) begin
         state_d = S_DONE;
         upd_zn  = 1'b1;
         c_d     = 1'b0;
         v_d     = 1'b0;
         ill_d   = 1'b0;
         case (opcode)
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_NOT:  res_d = ~a;
            OP_MOV:  res_d = a;
            OP_MOVI: res_d = b;
            OP_NOP:  res_d = '0;
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
               res_d = sum;
               c_d   = sum_c;
               v_d   = sum_v;
            end
            OP_SLL, OP_SRL: begin
               res_d  = a;
               cnt_d  = shamt;
               left_d = (opcode == OP_SLL);
               if (shamt != '0) state_d = S_SHIFT;
            end
            default: begin
               res_d = '0;
               ill_d = 1'b1;
            end
         endcase
      end

      if (upd_zn) begin
         z_d = (res_d == '0);
         n_d = res_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         z_q     <= z_d;
         n_q     <= n_d;
         c_q     <= c_d;
         v_q     <= v_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign halted    = (state_q == S_HALTED);
   assign out       = res_q;
   assign flag_z    = z_q;
   assign flag_n    = n_q;
   assign flag_c    = c_q;
   assign flag_v    = v_q;
   assign illegal   = ill_q;

endmodule
